// File: rtl/byte_group_reader_pkg.sv
// Shared widths and helpers for the byte group read path.
// idx_w() sizes the in-group position field (never narrower than 1 bit).
package byte_group_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int GRP_CNT_W  = 16;

    function automatic int idx_w(input int groupsize);
        return (groupsize <= 2) ? 1 : $clog2(groupsize);
    endfunction

endpackage

// File: rtl/byte_group_reader_skid_buffer.sv
// Purpose: 2-entry (main + skid) valid/ready buffer between the byte register stage and the consumer.
// Latency: 1 cycle from input transfer to out_dat when main is empty or drains in the same cycle.
// Backpressure: in_rdy is registered as ~skid_full, so it never depends combinationally on out_rdy.
module skid_buffer
    import byte_group_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_xfer
);

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic              in_rdy_q, in_rdy_d;
    logic              in_xfer;

    assign in_xfer  = in_vld & in_rdy_q;
    assign out_xfer = main_vld_q & out_rdy;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;

        if (out_xfer) begin
            if (skid_vld_q) begin
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end

        // New beat goes to main whenever main is (or is about to be) free; otherwise it parks in skid.
        if (in_xfer) begin
            if (!main_vld_d) begin
                main_vld_d = 1'b1;
                main_dat_d = in_dat;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_dat;
            end
        end

        in_rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_dat = main_dat_q;
    assign out_vld = main_vld_q;

endmodule

// File: rtl/byte_group_reader.sv
// Purpose: drains bytes through a skid buffer, tags each with its group position/last flag, counts groups (GROUP_PARITY_EN adds group XOR).
// Latency: 1 cycle in to out at full rate (1 beat/cycle with out_ready high).
// Backpressure: registered in_ready drops once the skid entry fills; outputs hold while out_valid & ~out_ready.
module byte_group_reader
    import byte_group_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int GROUPSIZE = 8,
    localparam int IDX_W     = idx_w(GROUPSIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [IDX_W-1:0]     out_index,
    output logic [GRP_CNT_W-1:0] group_count
`ifdef GROUP_PARITY_EN
    ,
    output logic [DATA_W-1:0]    out_parity
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPSIZE - 1);

    logic                 out_xfer;
    logic                 at_last;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GRP_CNT_W-1:0] cnt_q, cnt_d;

    skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_dat   (in_data),
        .in_vld   (in_valid),
        .in_rdy   (in_ready),
        .out_dat  (out_data),
        .out_vld  (out_valid),
        .out_rdy  (out_ready),
        .out_xfer (out_xfer)
    );

    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (out_xfer) begin
            if (at_last) begin
                idx_d = '0;
                cnt_d = cnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_last    = out_valid & at_last;
    assign out_index   = idx_q;
    assign group_count = cnt_q;

`ifdef GROUP_PARITY_EN
    // Accumulator excludes the beat on the bus, so the last beat is folded in combinationally.
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (out_xfer) begin
            acc_d = at_last ? '0 : (acc_q ^ out_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_parity = out_last ? (acc_q ^ out_data) : '0;
`endif

endmodule
